addsub_pipe: RTL

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides and registered N/Z/C/V flags. The N-bit operation is split into STAGES equal carry-chained chunks, one chunk per register stage, giving one result per cycle at STAGES-cycle latency. It sits in the datapath beside the combinational ALU adder and serves multi-cycle and wide arithmetic units that tolerate latency in exchange for a short critical path.

---
 rtl/addsub_pkg.sv | 39 +++
 rtl/addsub_chunk.sv | 29 ++
 rtl/addsub_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the pipelined adder/subtractor.
//   flags_t     : packed N/Z/C/V result flags
//   DEF_N       : default operand width
//   DEF_STAGES  : default pipeline depth
//   sat_pos/neg : saturation limits for an n-bit two's-complement result,
//                 returned right-aligned in a MAX_N-bit vector
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam int DEF_N      = 32;
    localparam int DEF_STAGES = 4;
    localparam int MAX_N      = 256;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Largest positive value: 2^(n-1) - 1
    function automatic logic [MAX_N-1:0] sat_pos(input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < n - 1; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Most negative value: -2^(n-1)
    function automatic logic [MAX_N-1:0] sat_neg(input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        r[n-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Combinational W-bit adder slice used once per pipeline stage.
//   a, b  in  W  operand slices (b already inverted for subtraction)
//   cin   in  1  carry in from the previous slice
//   sum   out W  slice sum
//   cout  out 1  carry out of the slice MSB
//   cmsb  out 1  carry into the slice MSB (for signed overflow detection)
// -----------------------------------------------------------------------------
module addsub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry-in can be recovered.
    assign cmsb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Pipelined two's-complement adder/subtractor. The N-bit operation is split
// into STAGES carry-chained chunks of W = N/STAGES bits, one chunk per
// register stage, with valid/ready handshakes on both sides.
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   A, B, Sub           operands; Sub=1 computes A-B
//   Sat                 saturate on signed overflow (ADDSUB_PIPE_SAT_EN only)
//   out_valid/out_ready output handshake
//   Sum, FlagN/Z/C/V    registered result and flags
// Build option: define ADDSUB_PIPE_SAT_EN to add the Sat port and clamping.
// Operand and partial-sum registers are kept right-shifted so each stage
// always works on the low W bits; the partial sum is assembled from the top.
// -----------------------------------------------------------------------------
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int STAGES = DEF_STAGES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Sub,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic         Sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         FlagN,
    output logic         FlagZ,
    output logic         FlagC,
    output logic         FlagV
);

    localparam int W  = N / STAGES;
    localparam int L  = STAGES - 1;                   // index of the last stage
    localparam int FW = (STAGES > 1) ? STAGES - 1 : 1;

    if (N % STAGES != 0) begin : g_width_check
        $fatal(1, "addsub_pipe: N (%0d) must be divisible by STAGES (%0d)", N, STAGES);
    end

`ifdef ADDSUB_PIPE_SAT_EN
    localparam logic [N-1:0] SAT_POS = N'(sat_pos(N));
    localparam logic [N-1:0] SAT_NEG = N'(sat_neg(N));
`endif

    // Inter-stage registers: entry k sits between stage k and stage k+1
    logic [STAGES-1:0] vld;
    logic [N-1:0]      fwd_a   [FW];
    logic [N-1:0]      fwd_b   [FW];
    logic [N-1:0]      fwd_sum [FW];
    logic [FW-1:0]     fwd_c;
`ifdef ADDSUB_PIPE_SAT_EN
    logic [FW-1:0]     fwd_sat;
`endif

    // Per-stage combinational inputs and chunk results
    logic [N-1:0]      st_a   [STAGES];
    logic [N-1:0]      st_b   [STAGES];
    logic [N-1:0]      st_sum [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_vld;
    logic [STAGES-1:0] st_sat;
    logic [W-1:0]      ch_sum [STAGES];
    logic [STAGES-1:0] ch_cout;
    logic [STAGES-1:0] ch_cmsb;
    logic [N-1:0]      nxt_sum [STAGES];
    logic [STAGES:0]   load;

    logic [N-1:0]      res_sum;
    flags_t            res_flags;
    logic [N-1:0]      sum_q;
    flags_t            flags_q;

    // Stage 0 takes the ports directly; later stages read the registers.
    // NOTE: every variable gets a value on every path through an always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        st_a[0]   = A;
        st_b[0]   = B ^ {N{Sub}};
        st_c[0]   = Sub;
        st_sum[0] = '0;
        st_vld[0] = in_valid;
`ifdef ADDSUB_PIPE_SAT_EN
        st_sat[0] = Sat;
`else
        st_sat[0] = 1'b0;
`endif
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]   = fwd_a[k-1];
            st_b[k]   = fwd_b[k-1];
            st_c[k]   = fwd_c[k-1];
            st_sum[k] = fwd_sum[k-1];
            st_vld[k] = vld[k-1];
`ifdef ADDSUB_PIPE_SAT_EN
            st_sat[k] = fwd_sat[k-1];
`else
            st_sat[k] = 1'b0;
`endif
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        addsub_chunk #(.W(W)) u_chunk (
            .a    (st_a[k][W-1:0]),
            .b    (st_b[k][W-1:0]),
            .cin  (st_c[k]),
            .sum  (ch_sum[k]),
            .cout (ch_cout[k]),
            .cmsb (ch_cmsb[k])
        );
    end

    // New chunk enters at the top; earlier chunks slide down by W.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum[k] = N'({ch_sum[k], st_sum[k]} >> W);
        end
    end

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        load[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !vld[k] || load[k+1];
        end
        in_ready = load[0] && !reset;
    end

    // Carry/overflow describe the raw result; N/Z follow the value driven out.
    always_comb begin
        res_flags.c = ch_cout[L];
        res_flags.v = ch_cmsb[L] ^ ch_cout[L];
        res_sum     = nxt_sum[L];
`ifdef ADDSUB_PIPE_SAT_EN
        if (st_sat[L] && res_flags.v) begin
            // A wrapped negative result means the true value overflowed upward.
            res_sum = nxt_sum[L][N-1] ? SAT_POS : SAT_NEG;
        end
`endif
        res_flags.n = res_sum[N-1];
        res_flags.z = (res_sum == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld     <= '0;
            sum_q   <= '0;
            flags_q <= '0;
            fwd_c   <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
            fwd_sat <= '0;
`endif
            // NOTE: the stage data arrays are plain flops, not RAM, so they
            // can be cleared here like any other register.
            for (int k = 0; k < FW; k++) begin
                fwd_a[k]   <= '0;
                fwd_b[k]   <= '0;
                fwd_sum[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) vld[k] <= st_vld[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (load[k] && st_vld[k]) begin
                    fwd_a[k]   <= st_a[k] >> W;
                    fwd_b[k]   <= st_b[k] >> W;
                    fwd_sum[k] <= nxt_sum[k];
                    fwd_c[k]   <= ch_cout[k];
`ifdef ADDSUB_PIPE_SAT_EN
                    fwd_sat[k] <= st_sat[k];
`endif
                end
            end
            // Last stage holds its result while stalled by out_ready.
            if (load[L] && st_vld[L]) begin
                sum_q   <= res_sum;
                flags_q <= res_flags;
            end
        end
    end

    assign out_valid = vld[L];
    assign Sum       = sum_q;
    assign FlagN     = flags_q.n;
    assign FlagZ     = flags_q.z;
    assign FlagC     = flags_q.c;
    assign FlagV     = flags_q.v;

endmodule
